// File: rtl/he_seq_ctrl.sv
// rtl/he_seq_ctrl.sv - histogram-equalization frame sequencer: histogram pass, table build, remap pass
// Optional macro HE_CTRL_PERF_EN adds the perf_cycles busy-cycle counter port.
module he_seq_ctrl #(
   parameter int IMAGE_WIDTH  = 660,
   parameter int IMAGE_HEIGHT = 440,
   parameter int ADDR_W       = 19
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              mem_rd_req,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic              mem_rd_valid,
   input  logic [7:0]        mem_rd_data,
   output logic              eng_clear,
   input  logic              eng_clear_done,
   output logic              eng_hist_we,
   output logic [7:0]        eng_hist_bin,
   output logic              eng_build,
   input  logic              eng_build_done,
   output logic [7:0]        eng_lut_addr,
   input  logic [7:0]        eng_lut_data,
   output logic              out_valid,
   output logic [7:0]        out_pixel,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
`ifdef HE_CTRL_PERF_EN
   ,
   output logic [31:0]       perf_cycles
`endif
);

   localparam int NUM_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

   typedef enum logic [3:0] {
      ST_IDLE, ST_CLEAR, ST_HIST, ST_FLUSH, ST_BUILD,
      ST_MAP_RD, ST_MAP_LUT, ST_MAP_OUT, ST_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              req_q, req_d;
   logic              clear_q, clear_d;
   logic              hist_we_q, hist_we_d;
   logic [7:0]        hist_bin_q, hist_bin_d;
   logic              build_q, build_d;
   logic [7:0]        lut_addr_q, lut_addr_d;
   logic              out_valid_q, out_valid_d;
   logic [7:0]        out_pixel_q, out_pixel_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      req_d       = req_q;
      clear_d     = 1'b0;
      hist_we_d   = 1'b0;
      hist_bin_d  = hist_bin_q;
      build_d     = 1'b0;
      lut_addr_d  = lut_addr_q;
      out_valid_d = out_valid_q;
      out_pixel_d = out_pixel_q;
      done_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               clear_d = 1'b1;
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            if (eng_clear_done) begin
               addr_d  = '0;
               req_d   = 1'b1;
               state_d = ST_HIST;
            end
         end
         ST_HIST: begin
            if (req_q && mem_rd_valid) begin
               hist_we_d  = 1'b1;
               hist_bin_d = mem_rd_data;
               if (addr_q == LAST_ADDR) begin
                  req_d   = 1'b0;
                  state_d = ST_FLUSH;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         ST_FLUSH: begin
            build_d = 1'b1;
            state_d = ST_BUILD;
         end
         ST_BUILD: begin
            if (eng_build_done) begin
               addr_d  = '0;
               state_d = ST_MAP_RD;
            end
         end
         // The request rises in the first MAP_RD cycle, so each remap read costs one extra cycle.
         ST_MAP_RD: begin
            if (req_q && mem_rd_valid) begin
               lut_addr_d = mem_rd_data;
               req_d      = 1'b0;
               state_d    = ST_MAP_LUT;
            end else begin
               req_d = 1'b1;
            end
         end
         ST_MAP_LUT: begin
            out_pixel_d = eng_lut_data;
            out_valid_d = 1'b1;
            state_d     = ST_MAP_OUT;
         end
         ST_MAP_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (addr_q == LAST_ADDR) begin
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  addr_d  = addr_q + 1'b1;
                  state_d = ST_MAP_RD;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         req_q       <= 1'b0;
         clear_q     <= 1'b0;
         hist_we_q   <= 1'b0;
         hist_bin_q  <= '0;
         build_q     <= 1'b0;
         lut_addr_q  <= '0;
         out_valid_q <= 1'b0;
         out_pixel_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         req_q       <= req_d;
         clear_q     <= clear_d;
         hist_we_q   <= hist_we_d;
         hist_bin_q  <= hist_bin_d;
         build_q     <= build_d;
         lut_addr_q  <= lut_addr_d;
         out_valid_q <= out_valid_d;
         out_pixel_q <= out_pixel_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign mem_rd_req   = req_q;
   assign mem_rd_addr  = addr_q;
   assign eng_clear    = clear_q;
   assign eng_hist_we  = hist_we_q;
   assign eng_hist_bin = hist_bin_q;
   assign eng_build    = build_q;
   assign eng_lut_addr = lut_addr_q;
   assign out_valid    = out_valid_q;
   assign out_pixel    = out_pixel_q;
   assign busy         = busy_q;
   assign done         = done_q;

`ifdef HE_CTRL_PERF_EN
   logic [31:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (state_q == ST_IDLE) begin
         if (start) perf_d = '0;
      end else if (perf_q != 32'hFFFF_FFFF) begin
         perf_d = perf_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) perf_q <= '0;
      else        perf_q <= perf_d;
   end

   assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_he_seq_ctrl.sv
// tb/tb_he_seq_ctrl.sv - directed self-checking bench for he_seq_ctrl on a 4x2 frame
// Optional macro HE_CTRL_PERF_EN enables the perf_cycles checks.
module tb_he_seq_ctrl;

   localparam int W  = 4;
   localparam int H  = 2;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          mem_rd_req;
   logic [AW-1:0] mem_rd_addr;
   logic          mem_rd_valid = 1'b0;
   logic [7:0]    mem_rd_data = 8'd0;
   logic          eng_clear;
   logic          eng_clear_done = 1'b0;
   logic          eng_hist_we;
   logic [7:0]    eng_hist_bin;
   logic          eng_build;
   logic          eng_build_done = 1'b0;
   logic [7:0]    eng_lut_addr;
   logic [7:0]    eng_lut_data = 8'd0;
   logic          out_valid;
   logic [7:0]    out_pixel;
   logic          out_ready = 1'b1;
   logic          busy;
   logic          done;
`ifdef HE_CTRL_PERF_EN
   logic [31:0]   perf_cycles;
`endif

   he_seq_ctrl #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .start(start),
      .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
      .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
      .eng_clear(eng_clear), .eng_clear_done(eng_clear_done),
      .eng_hist_we(eng_hist_we), .eng_hist_bin(eng_hist_bin),
      .eng_build(eng_build), .eng_build_done(eng_build_done),
      .eng_lut_addr(eng_lut_addr), .eng_lut_data(eng_lut_data),
      .out_valid(out_valid), .out_pixel(out_pixel), .out_ready(out_ready),
      .busy(busy), .done(done)
`ifdef HE_CTRL_PERF_EN
      , .perf_cycles(perf_cycles)
`endif
   );

   always #5 clk = ~clk;

   logic [7:0] frame   [0:7] = '{8'd0, 8'd0, 8'd10, 8'd10, 8'd10, 8'd200, 8'd255, 8'd255};
   logic [7:0] exp_out [0:7] = '{8'd255, 8'd255, 8'd245, 8'd245, 8'd245, 8'd55, 8'd0, 8'd0};

   int checks = 0;
   int errors = 0;

   // Stimulus knobs, written only by the directed sequence.
   logic wait_mode = 1'b0;
   logic stall_en = 1'b0;
   logic spur_build = 1'b0;

   // Environment model and monitor state, written only by the negedge process.
   int         cyc = 0;
   int         clr_cnt = 0, bld_cnt = 0;
   logic       in_hist = 1'b0;
   logic [7:0] hist_log [0:127];
   logic [7:0] out_log  [0:127];
   int         hist_n = 0, out_n = 0, build_n = 0, done_n = 0, clear_n = 0, busy_n = 0;
   int         last_we_cyc = 0, build_cyc = 0, last_hs_cyc = 0, done_cyc = 0;
   int         lag_err = 0, addr_err = 0, stall_err = 0, stall_cnt = 0;
   logic [7:0] stall_pix = 8'd0;
   logic       prev_acc = 1'b0, prev_req = 1'b0, prev_valid = 1'b0, prev_stall = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic [7:0] prev_pix = 8'd0, prev_lut = 8'd0;

   always @(negedge clk) begin
      cyc++;
      if (eng_hist_we !== prev_acc) lag_err++;
      if (prev_req && !prev_valid && mem_rd_req && mem_rd_addr !== prev_addr) addr_err++;
      if (prev_stall && (!out_valid || out_pixel !== prev_pix || eng_lut_addr !== prev_lut)) stall_err++;
      if (eng_hist_we) begin
         hist_log[hist_n] = eng_hist_bin;
         hist_n++;
         last_we_cyc = cyc;
      end
      if (eng_clear) begin
         clear_n++;
         in_hist = 1'b1;
      end
      if (eng_build) begin
         build_n++;
         build_cyc = cyc;
         in_hist = 1'b0;
      end
      if (done) begin
         done_n++;
         done_cyc = cyc;
      end
      if (busy) busy_n++;
      if (eng_clear) clr_cnt = 4;
      else if (clr_cnt != 0) clr_cnt--;
      if (eng_build) bld_cnt = 6;
      else if (bld_cnt != 0) bld_cnt--;
      eng_clear_done = (clr_cnt == 1);
      eng_build_done = (bld_cnt == 1) || spur_build;
      mem_rd_valid = mem_rd_req && (!wait_mode || (cyc % 3 == 0));
      mem_rd_data = frame[mem_rd_addr];
      // Table data settles within the MAP_LUT cycle for the address registered on entry.
      eng_lut_data = eng_lut_addr ^ 8'hFF;
      out_ready = !(stall_en && out_valid && (out_n % 8 == 3) && stall_cnt < 5);
      if (out_valid && !out_ready) begin
         stall_cnt++;
         stall_pix = out_pixel;
         if (mem_rd_req) stall_err++;
      end
      if (out_valid && out_ready) begin
         out_log[out_n] = out_pixel;
         out_n++;
         last_hs_cyc = cyc;
      end
      prev_acc   = in_hist && mem_rd_req && mem_rd_valid;
      prev_req   = mem_rd_req;
      prev_valid = mem_rd_valid;
      prev_addr  = mem_rd_addr;
      prev_stall = out_valid && !out_ready;
      prev_pix   = out_pixel;
      prev_lut   = eng_lut_addr;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [63:0] all_outs();
      return {30'd0, mem_rd_req, mem_rd_addr, eng_clear, eng_hist_we, eng_hist_bin,
              eng_build, eng_lut_addr, out_valid, out_pixel, busy, done};
   endfunction

   task automatic run_frame(input string tag, input bit spur);
      int hb, ob, bb, db, cb, b0, t;
      hb = hist_n; ob = out_n; bb = build_n; db = done_n; cb = clear_n; b0 = busy_n;
      start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_clear_pulse"}, {62'd0, eng_clear, busy}, 64'd3);
`ifdef HE_CTRL_PERF_EN
      check({tag, "_perf_cleared"}, perf_cycles, 64'd0);
`endif
      if (spur) begin
         t = 0;
         while (hist_n < hb + 2 && t < 200) begin
            tick();
            t++;
         end
         start = 1'b1;
         spur_build = 1'b1;
         tick();
         start = 1'b0;
         spur_build = 1'b0;
      end
      t = 0;
      while (done_n == db && t < 2000) begin
         tick();
         t++;
      end
      check({tag, "_idle_after_done"}, {62'd0, busy, done}, 64'd0);
      for (int i = 0; i < 4; i++) tick();
      check({tag, "_done_count"}, done_n - db, 64'd1);
      check({tag, "_clear_count"}, clear_n - cb, 64'd1);
      check({tag, "_hist_count"}, hist_n - hb, 64'd8);
      check({tag, "_out_count"}, out_n - ob, 64'd8);
      check({tag, "_build_count"}, build_n - bb, 64'd1);
      check({tag, "_build_lag"}, build_cyc - last_we_cyc, 64'd1);
      check({tag, "_done_lag"}, done_cyc - last_hs_cyc, 64'd1);
      for (int i = 0; i < 8; i++) begin
         check({tag, "_hist_bin"}, hist_log[hb + i], frame[i]);
         check({tag, "_out_pixel"}, out_log[ob + i], exp_out[i]);
      end
`ifdef HE_CTRL_PERF_EN
      check({tag, "_perf_cycles"}, perf_cycles, busy_n - b0);
      for (int i = 0; i < 5; i++) tick();
      check({tag, "_perf_hold"}, perf_cycles, busy_n - b0);
`endif
   endtask

   initial begin
      int ob, db, t;
      for (int i = 0; i < 3; i++) tick();
      check("reset_outputs", all_outs(), 64'd0);
`ifdef HE_CTRL_PERF_EN
      check("reset_perf", perf_cycles, 64'd0);
`endif
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle_outputs", all_outs(), 64'd0);
      end

      run_frame("full", 1'b0);

      stall_en = 1'b1;
      run_frame("stall", 1'b0);
      stall_en = 1'b0;
      check("stall_cycles", stall_cnt, 64'd5);
      check("stall_pixel", stall_pix, 64'd245);
      check("stall_hold_errs", stall_err, 64'd0);

      wait_mode = 1'b1;
      run_frame("wait", 1'b0);
      wait_mode = 1'b0;
      check("addr_stable_errs", addr_err, 64'd0);

      run_frame("spurious", 1'b1);

      ob = out_n;
      db = done_n;
      start = 1'b1;
      tick();
      start = 1'b0;
      t = 0;
      while (!(out_n - ob >= 4 && out_valid) && t < 500) begin
         tick();
         t++;
      end
      check("abort_in_map_out", {63'd0, out_valid}, 64'd1);
      reset = 1'b0;
      tick();
      check("abort_outputs", all_outs(), 64'd0);
      for (int i = 0; i < 3; i++) tick();
      check("abort_no_done", done_n - db, 64'd0);
      reset = 1'b1;
      tick();
      run_frame("after_abort", 1'b0);

      check("hist_lag_errs", lag_err, 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
